// File: rtl/ppu_pkg.sv
// rtl/ppu_pkg.sv - shared PPU memory-side types, address map and helpers
// Purpose: PPU mode and OAM DMA state encodings, VRAM/OAM/DMA register
//          address constants, and an inclusive address-range helper.
// Ports:   none (package)
package ppu_pkg;

    typedef enum logic [1:0] {
        PPU_HBLANK = 2'd0,
        PPU_VBLANK = 2'd1,
        PPU_SCAN   = 2'd2,
        PPU_DRAW   = 2'd3
    } PPU_STATES_t;

    typedef enum logic [2:0] {
        DMA_IDLE,
        DMA_START,
        DMA_REQ,
        DMA_WAIT,
        DMA_WRITE
    } DMA_STATES_t;

    localparam logic [15:0] VRAM_BASE     = 16'h8000;
    localparam logic [15:0] VRAM_END      = 16'h9FFF;
    localparam logic [15:0] OAM_BASE      = 16'hFE00;
    localparam logic [15:0] OAM_END       = 16'hFE9F;
    localparam logic [15:0] UNUSABLE_BASE = 16'hFEA0;
    localparam logic [15:0] UNUSABLE_END  = 16'hFEFF;
    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;

    function automatic logic in_range(input logic [15:0] a,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (a >= lo) && (a <= hi);
    endfunction

endpackage

// File: rtl/ppu_oam_dma.sv
// rtl/ppu_oam_dma.sv - FF46 OAM DMA copy engine
// Purpose: copies OAM_BYTES bytes from {src_hi,00}+idx on the system read
//          bus into OAM, one byte every CLKS_PER_BYTE clocks.
// Ports:   clk, rst (sync, active-low)
//          cpu_wr/cpu_addr/cpu_wdata : CPU write bus, watched for FF46
//          dma_data                  : source byte, valid 2 clk after dma_rd
//          dma_rd/dma_addr           : source read strobe and address
//          dma_active                : transfer in progress
//          oam_we/oam_waddr/oam_wdata: OAM write port
module ppu_oam_dma
    import ppu_pkg::*;
#(
    parameter int OAM_BYTES     = 160,
    parameter int CLKS_PER_BYTE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic [7:0]  dma_data,
    output logic        dma_rd,
    output logic [15:0] dma_addr,
    output logic        dma_active,
    output logic        oam_we,
    output logic [7:0]  oam_waddr,
    output logic [7:0]  oam_wdata
);

    localparam logic [7:0] LAST_IDX  = 8'(OAM_BYTES - 1);
    // REQ and WRITE each take one clock; WAIT fills the rest of the byte slot.
    localparam logic [7:0] WAIT_LAST = 8'(CLKS_PER_BYTE - 3);

    DMA_STATES_t state_q, state_d;
    logic [7:0]  src_hi_q, src_hi_d;
    logic [7:0]  idx_q, idx_d;
    logic [7:0]  wait_q, wait_d;
    logic        rd_q, rd_d;
    logic [15:0] addr_q, addr_d;
    logic        active_q, active_d;
    logic        start_req;

    assign start_req = cpu_wr && (cpu_addr == DMA_REG_ADDR);

    always_comb begin
        state_d  = state_q;
        src_hi_d = src_hi_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        rd_d     = rd_q;
        addr_d   = addr_q;
        active_d = active_q;
        if (start_req) begin
            // Any FF46 write, idle or mid-transfer, (re)starts from byte 0.
            src_hi_d = cpu_wdata;
            idx_d    = 8'h00;
            rd_d     = 1'b0;
            active_d = 1'b1;
            state_d  = DMA_START;
        end else begin
            case (state_q)
                DMA_IDLE: ;
                DMA_START: begin
                    idx_d   = 8'h00;
                    rd_d    = 1'b1;
                    addr_d  = {src_hi_q, 8'h00};
                    state_d = DMA_REQ;
                end
                DMA_REQ: begin
                    rd_d    = 1'b0;
                    wait_d  = 8'h00;
                    state_d = DMA_WAIT;
                end
                DMA_WAIT: begin
                    if (wait_q == WAIT_LAST) begin
                        state_d = DMA_WRITE;
                    end else begin
                        wait_d = wait_q + 8'd1;
                    end
                end
                DMA_WRITE: begin
                    if (idx_q == LAST_IDX) begin
                        active_d = 1'b0;
                        state_d  = DMA_IDLE;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        rd_d    = 1'b1;
                        addr_d  = {src_hi_q, 8'h00} + {8'h00, idx_q + 8'd1};
                        state_d = DMA_REQ;
                    end
                end
                default: state_d = DMA_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= DMA_IDLE;
            src_hi_q <= 8'h00;
            idx_q    <= 8'h00;
            wait_q   <= 8'h00;
            rd_q     <= 1'b0;
            addr_q   <= 16'h0000;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            src_hi_q <= src_hi_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            rd_q     <= rd_d;
            addr_q   <= addr_d;
            active_q <= active_d;
        end
    end

    // A restart or reset landing on the WRITE cycle drops that byte.
    assign oam_we     = rst && (state_q == DMA_WRITE) && !start_req;
    assign oam_waddr  = idx_q;
    assign oam_wdata  = dma_data;
    assign dma_rd     = rd_q;
    assign dma_addr   = addr_q;
    assign dma_active = active_q;

endmodule

// File: rtl/ppu_vmem_responder.sv
// rtl/ppu_vmem_responder.sv - VRAM/OAM responder for PPU fetch, CPU and OAM DMA
// Purpose: owns VRAM and OAM, serves PPU reads with 2-clock latency,
//          applies CPU lockout by PPU mode, and hosts the FF46 DMA engine.
// Ports:   clk, rst (sync, active-low)
//          PPU_RD/PPU_ADDR/PPU_DATA_in : PPU fetch port (registered data)
//          PPU_MODE/LCD_EN             : PPU mode and LCDC[7], for lockout
//          ADDR/WR/RD/MMIO_DATA_out    : CPU bus in
//          MMIO_DATA_in                : CPU read data (combinational)
//          DMA_RD/DMA_ADDR/DMA_DATA    : DMA source read bus
//          DMA_ACTIVE                  : DMA in progress
module ppu_vmem_responder
    import ppu_pkg::*;
#(
    parameter int VRAM_AW           = 13,
    parameter int OAM_BYTES         = 160,
    parameter int DMA_CLKS_PER_BYTE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PPU_RD,
    input  logic [15:0] PPU_ADDR,
    output logic [7:0]  PPU_DATA_in,
    input  logic [1:0]  PPU_MODE,
    input  logic        LCD_EN,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic        RD,
    input  logic [7:0]  MMIO_DATA_out,
    output logic [7:0]  MMIO_DATA_in,
    output logic        DMA_RD,
    output logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_DATA,
    output logic        DMA_ACTIVE
);

    localparam int          VRAM_BYTES = 1 << VRAM_AW;
    localparam logic [15:0] VRAM_LAST  = 16'(VRAM_BASE + VRAM_BYTES - 1);
    localparam logic [15:0] OAM_LAST   = 16'(OAM_BASE + OAM_BYTES - 1);

    logic [7:0] vram_mem [VRAM_BYTES];
    logic [7:0] oam_mem  [OAM_BYTES];

    PPU_STATES_t ppu_mode;
    logic        vram_lock, oam_lock;
    logic        cpu_in_vram, cpu_in_oam;
    logic        vram_cpu_we, oam_cpu_we;
    logic        dma_oam_we;
    logic [7:0]  dma_oam_waddr, dma_oam_wdata;
    logic        dma_active;
    logic [15:0] ppu_addr_q, ppu_addr_d;
    logic [7:0]  ppu_data_q, ppu_data_d;

    ppu_oam_dma #(
        .OAM_BYTES     (OAM_BYTES),
        .CLKS_PER_BYTE (DMA_CLKS_PER_BYTE)
    ) u_dma (
        .clk        (clk),
        .rst        (rst),
        .cpu_wr     (WR),
        .cpu_addr   (ADDR),
        .cpu_wdata  (MMIO_DATA_out),
        .dma_data   (DMA_DATA),
        .dma_rd     (DMA_RD),
        .dma_addr   (DMA_ADDR),
        .dma_active (dma_active),
        .oam_we     (dma_oam_we),
        .oam_waddr  (dma_oam_waddr),
        .oam_wdata  (dma_oam_wdata)
    );

    assign DMA_ACTIVE = dma_active;
    assign ppu_mode   = PPU_STATES_t'(PPU_MODE);

    // DMA owns OAM even with the LCD off; mode-based lockout needs LCD_EN.
    assign vram_lock   = LCD_EN && (ppu_mode == PPU_DRAW);
    assign oam_lock    = dma_active ||
                         (LCD_EN && (ppu_mode == PPU_SCAN || ppu_mode == PPU_DRAW));
    assign cpu_in_vram = in_range(ADDR, VRAM_BASE, VRAM_LAST);
    assign cpu_in_oam  = in_range(ADDR, OAM_BASE, OAM_LAST);
    assign vram_cpu_we = WR && cpu_in_vram && !vram_lock;
    assign oam_cpu_we  = WR && cpu_in_oam && !oam_lock;

    always_comb begin
        MMIO_DATA_in = 8'hFF;
        if (RD) begin
            if (cpu_in_vram && !vram_lock) begin
                MMIO_DATA_in = vram_mem[ADDR[VRAM_AW-1:0]];
            end else if (cpu_in_oam && !oam_lock) begin
                MMIO_DATA_in = oam_mem[ADDR[7:0]];
            end
        end
    end

    // PPU fetch: address captured while PPU_RD is high, array read into the
    // output register on every clock so data holds once PPU_RD drops.
    always_comb begin
        ppu_addr_d = PPU_RD ? PPU_ADDR : ppu_addr_q;
        ppu_data_d = 8'hFF;
        if (in_range(ppu_addr_q, VRAM_BASE, VRAM_LAST)) begin
            ppu_data_d = vram_mem[ppu_addr_q[VRAM_AW-1:0]];
        end else if (in_range(ppu_addr_q, OAM_BASE, OAM_LAST)) begin
            ppu_data_d = dma_active ? 8'hFF : oam_mem[ppu_addr_q[7:0]];
        end else if (in_range(ppu_addr_q, UNUSABLE_BASE, UNUSABLE_END)) begin
            ppu_data_d = 8'h00;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ppu_addr_q <= 16'h0000;
            ppu_data_q <= 8'h00;
        end else begin
            ppu_addr_q <= ppu_addr_d;
            ppu_data_q <= ppu_data_d;
        end
    end

    assign PPU_DATA_in = ppu_data_q;

    // Arrays are never cleared; a same-cycle write and PPU read of one byte
    // returns the old byte because the read above samples before the update.
    always_ff @(posedge clk) begin
        if (vram_cpu_we) begin
            vram_mem[ADDR[VRAM_AW-1:0]] <= MMIO_DATA_out;
        end
        if (dma_oam_we) begin
            oam_mem[dma_oam_waddr] <= dma_oam_wdata;
        end else if (oam_cpu_we) begin
            oam_mem[ADDR[7:0]] <= MMIO_DATA_out;
        end
    end

endmodule
